// File: rtl/floo_pkg.sv
// Shared FlooNoC definitions used by the wide-only chimney link arbiter.
//   cls_e          : traffic class index (narrow = 0, wide = 1)
//   WoNarrowWeight : default narrow packets per turn under contention
//   WoWideWeight   : default wide packets per turn under contention
package floo_pkg;

  typedef enum logic {
    ClsNarrow = 1'b0,
    ClsWide   = 1'b1
  } cls_e;

  localparam int unsigned WoNarrowWeight = 32'd1;
  localparam int unsigned WoWideWeight   = 32'd4;

endpackage

// File: rtl/floo_wide_only_flit_pkg.sv
// Flit type carried on the wide-only physical link.
//   flit_t : 64-bit link flit
package floo_wide_only_flit_pkg;

  typedef logic [63:0] flit_t;

endpackage

// File: rtl/floo_wide_only_link_arbiter_checker.sv
// Protocol checker for floo_wide_only_link_arbiter.
// Ports (all inputs): clk_i, rst_ni, the narrow/wide valid+ready pairs,
// the link valid_o and ready_i.
// Checks: weights >= 1, inputs hold valid until accepted, link valid is
// stable under backpressure.
module floo_wide_only_link_arbiter_checker #(
  parameter int unsigned NarrowWeight = 32'd1,
  parameter int unsigned WideWeight   = 32'd4
) (
  input logic clk_i,
  input logic rst_ni,
  input logic narrow_valid_i,
  input logic narrow_ready_o,
  input logic wide_valid_i,
  input logic wide_ready_o,
  input logic valid_o,
  input logic ready_i
);

  // Configuration sanity: each class must be allowed at least one packet.
  weights_ok: assert property (@(posedge clk_i)
    (NarrowWeight >= 32'd1) && (WideWeight >= 32'd1));

  // Narrow source keeps its flit offered until it is taken.
  narrow_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (narrow_valid_i && !narrow_ready_o) |=> narrow_valid_i);

  // Wide source keeps its flit offered until it is taken.
  wide_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (wide_valid_i && !wide_ready_o) |=> wide_valid_i);

  // Link output never withdraws a presented flit.
  link_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> valid_o);

endmodule

// File: rtl/floo_wide_only_link_arbiter.sv
// Weighted round-robin arbiter sharing the single wide link of a wide-only
// chimney between the narrow and the wide flit stream, with wormhole
// locking so a multi-flit packet is never interleaved with the other class.
// The grant path is combinational; arbitration state is registered.
//
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   narrow_valid_i/ready_o/data_i/last_i  narrow flit stream
//   wide_valid_i/ready_o/data_i/last_i    wide flit stream
//   valid_o, ready_i, data_o          link flit stream
//   sel_o                             current source (0 narrow, 1 wide)
// Optional (macro FLOO_WO_ARB_PERF_EN):
//   narrow_pkts_o, wide_pkts_o        completed packets per class
//   contention_cycles_o               cycles with both classes valid
module floo_wide_only_link_arbiter
  import floo_pkg::*;
#(
  parameter type         flit_t       = floo_wide_only_flit_pkg::flit_t,
  parameter int unsigned NarrowWeight = WoNarrowWeight,
  parameter int unsigned WideWeight   = WoWideWeight
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  narrow_valid_i,
  output logic  narrow_ready_o,
  input  flit_t narrow_data_i,
  input  logic  narrow_last_i,
  input  logic  wide_valid_i,
  output logic  wide_ready_o,
  input  flit_t wide_data_i,
  input  logic  wide_last_i,
  output logic  valid_o,
  input  logic  ready_i,
  output flit_t data_o,
  output logic  sel_o
`ifdef FLOO_WO_ARB_PERF_EN
  ,
  output logic [31:0] narrow_pkts_o,
  output logic [31:0] wide_pkts_o,
  output logic [31:0] contention_cycles_o
`endif
);

  localparam int unsigned MaxWeight = (NarrowWeight > WideWeight) ? NarrowWeight : WideWeight;
  localparam int unsigned CntWidth  = $clog2(MaxWeight + 32'd1);

  logic                prio_q, prio_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                lock_q, lock_d;
  logic                lock_sel_q, lock_sel_d;
  logic                hold_q, hold_d;
  logic                hold_sel_q, hold_sel_d;

  logic                sel;
  logic                valid_prio;
  logic                valid_other;
  logic                valid_sel;
  logic                last_sel;
  logic                hs;
  logic [CntWidth-1:0] weight_prio;
  logic [CntWidth-1:0] cnt_next;

  // Source selection and link mux. While reset is asserted the outputs are
  // forced to their idle values independently of the inputs.
  always_comb begin
    valid_prio  = (prio_q == ClsWide) ? wide_valid_i : narrow_valid_i;
    valid_other = (prio_q == ClsWide) ? narrow_valid_i : wide_valid_i;
    if (!rst_ni) begin
      sel = ClsNarrow;
    end else if (lock_q) begin
      sel = lock_sel_q;
    end else if (hold_q) begin
      sel = hold_sel_q;
    end else if (valid_prio) begin
      sel = prio_q;
    end else if (valid_other) begin
      sel = ~prio_q;
    end else begin
      sel = prio_q;
    end
    valid_sel      = (sel == ClsWide) ? wide_valid_i : narrow_valid_i;
    last_sel       = (sel == ClsWide) ? wide_last_i : narrow_last_i;
    valid_o        = rst_ni & valid_sel;
    data_o         = (sel == ClsWide) ? wide_data_i : narrow_data_i;
    sel_o          = sel;
    narrow_ready_o = rst_ni & (sel == ClsNarrow) & ready_i;
    wide_ready_o   = rst_ni & (sel == ClsWide) & ready_i;
    hs             = valid_o & ready_i;
  end

  // Next-state for lock, grant hold and the weighted round-robin bookkeeping.
  always_comb begin
    weight_prio = (prio_q == ClsWide) ? CntWidth'(WideWeight) : CntWidth'(NarrowWeight);
    // Saturating increment: once the favoured class has used its quota the
    // next completed packet hands over as soon as the other class waits.
    cnt_next    = (cnt_q >= weight_prio) ? weight_prio : (cnt_q + CntWidth'(1));
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    lock_d      = lock_q;
    lock_sel_d  = lock_sel_q;
    hold_d      = valid_o & ~ready_i;
    hold_sel_d  = sel;
    if (hs) begin
      if (last_sel) begin
        lock_d = 1'b0;
        if (sel == prio_q) begin
          if ((cnt_next == weight_prio) && valid_other) begin
            prio_d = ~prio_q;
            cnt_d  = '0;
          end else begin
            cnt_d  = cnt_next;
          end
        end else begin
          // Favoured class was idle: work-conserving grant, no penalty.
          cnt_d = cnt_q;
        end
      end else begin
        lock_d     = 1'b1;
        lock_sel_d = sel;
      end
    end else begin
      lock_d = lock_q;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      hold_q     <= 1'b0;
      hold_sel_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      hold_q     <= hold_d;
      hold_sel_q <= hold_sel_d;
    end
  end

`ifdef FLOO_WO_ARB_PERF_EN
  logic [31:0] narrow_pkts_q;
  logic [31:0] wide_pkts_q;
  logic [31:0] contention_q;

  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      narrow_pkts_q <= 32'd0;
      wide_pkts_q   <= 32'd0;
      contention_q  <= 32'd0;
    end else begin
      if (hs && last_sel && (sel == ClsNarrow)) begin
        narrow_pkts_q <= narrow_pkts_q + 32'd1;
      end else begin
        narrow_pkts_q <= narrow_pkts_q;
      end
      if (hs && last_sel && (sel == ClsWide)) begin
        wide_pkts_q <= wide_pkts_q + 32'd1;
      end else begin
        wide_pkts_q <= wide_pkts_q;
      end
      if (narrow_valid_i && wide_valid_i) begin
        contention_q <= contention_q + 32'd1;
      end else begin
        contention_q <= contention_q;
      end
    end
  end

  assign narrow_pkts_o       = narrow_pkts_q;
  assign wide_pkts_o         = wide_pkts_q;
  assign contention_cycles_o = contention_q;
`endif

  floo_wide_only_link_arbiter_checker #(
    .NarrowWeight (NarrowWeight),
    .WideWeight   (WideWeight)
  ) i_checker (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .narrow_valid_i (narrow_valid_i),
    .narrow_ready_o (narrow_ready_o),
    .wide_valid_i   (wide_valid_i),
    .wide_ready_o   (wide_ready_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i)
  );

endmodule

// File: tb/tb_floo_wide_only_link_arbiter.sv
// Directed self-checking bench for floo_wide_only_link_arbiter with the
// default weights (narrow 1, wide 4). Inputs change 1 time unit after the
// rising edge; outputs are compared 1 time unit later, mid-cycle.
module tb_floo_wide_only_link_arbiter;

  logic        clk_i;
  logic        rst_ni;
  logic        narrow_valid_i;
  logic        narrow_ready_o;
  logic [63:0] narrow_data_i;
  logic        narrow_last_i;
  logic        wide_valid_i;
  logic        wide_ready_o;
  logic [63:0] wide_data_i;
  logic        wide_last_i;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] data_o;
  logic        sel_o;
`ifdef FLOO_WO_ARB_PERF_EN
  logic [31:0] narrow_pkts_o;
  logic [31:0] wide_pkts_o;
  logic [31:0] contention_cycles_o;
`endif

  int checks;
  int errors;

  floo_wide_only_link_arbiter dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .narrow_valid_i (narrow_valid_i),
    .narrow_ready_o (narrow_ready_o),
    .narrow_data_i  (narrow_data_i),
    .narrow_last_i  (narrow_last_i),
    .wide_valid_i   (wide_valid_i),
    .wide_ready_o   (wide_ready_o),
    .wide_data_i    (wide_data_i),
    .wide_last_i    (wide_last_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .data_o         (data_o),
    .sel_o          (sel_o)
`ifdef FLOO_WO_ARB_PERF_EN
    ,
    .narrow_pkts_o       (narrow_pkts_o),
    .wide_pkts_o         (wide_pkts_o),
    .contention_cycles_o (contention_cycles_o)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Expected grant order with both classes always offering single-flit packets.
  bit exp_seq [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    checks         = 0;
    errors         = 0;
    rst_ni         = 1'b0;
    ready_i        = 1'b1;
    narrow_valid_i = 1'b1;
    narrow_data_i  = 64'h0000_0000_0000_A000;
    narrow_last_i  = 1'b1;
    wide_valid_i   = 1'b1;
    wide_data_i    = 64'h0000_0000_0000_B000;
    wide_last_i    = 1'b1;

    // Reset: outputs idle even with both sources valid.
    #2;
    check_eq("rst_valid", valid_o, 1'b0);
    check_eq("rst_nready", narrow_ready_o, 1'b0);
    check_eq("rst_wready", wide_ready_o, 1'b0);
    check_eq("rst_sel", sel_o, 1'b0);
    check_eq("rst_data", data_o, 64'h0000_0000_0000_A000);
    wide_valid_i = 1'b0;
    cycle();
    cycle();
    rst_ni = 1'b1;

    // Narrow only: three single-flit packets back to back.
    for (int i = 0; i < 3; i++) begin
      narrow_data_i = 64'h0000_0000_0000_A000 + 64'(i);
      #1;
      check_eq("n_only_valid", valid_o, 1'b1);
      check_eq("n_only_sel", sel_o, 1'b0);
      check_eq("n_only_ready", narrow_ready_o, 1'b1);
      check_eq("n_only_data", data_o, 64'h0000_0000_0000_A000 + 64'(i));
      cycle();
    end

    // Contention with single-flit packets: weighted alternation 1:4.
    narrow_data_i = 64'h0000_0000_0000_A100;
    wide_data_i   = 64'h0000_0000_0000_B100;
    wide_valid_i  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      #1;
      check_eq("wrr_sel", sel_o, exp_seq[i]);
      check_eq("wrr_valid", valid_o, 1'b1);
      check_eq("wrr_data", data_o, exp_seq[i] ? 64'h0000_0000_0000_B100 : 64'h0000_0000_0000_A100);
      cycle();
    end

    // Wide 8-flit burst; narrow arrives at flit 2 and must wait for the last flit.
    narrow_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wide_last_i    = (i == 7);
      wide_data_i    = 64'h0000_0000_0000_B200 + 64'(i);
      narrow_valid_i = (i >= 2);
      narrow_data_i  = 64'h0000_0000_0000_A200;
      #1;
      check_eq("burst_sel", sel_o, 1'b1);
      check_eq("burst_data", data_o, 64'h0000_0000_0000_B200 + 64'(i));
      if (i >= 2) begin
        check_eq("burst_nready", narrow_ready_o, 1'b0);
      end
      cycle();
    end
    wide_valid_i = 1'b0;
    #1;
    check_eq("after_burst_sel", sel_o, 1'b0);
    check_eq("after_burst_nready", narrow_ready_o, 1'b1);
    check_eq("after_burst_data", data_o, 64'h0000_0000_0000_A200);
    cycle();

    // Locked wide packet with a 3-cycle hole: link idles, narrow not granted.
    narrow_data_i = 64'h0000_0000_0000_A300;
    wide_valid_i  = 1'b1;
    wide_last_i   = 1'b0;
    wide_data_i   = 64'h0000_0000_0000_B300;
    #1;
    check_eq("hole_first_sel", sel_o, 1'b1);
    cycle();
    wide_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("hole_valid", valid_o, 1'b0);
      check_eq("hole_sel", sel_o, 1'b1);
      check_eq("hole_nready", narrow_ready_o, 1'b0);
      cycle();
    end
    wide_valid_i = 1'b1;
    wide_last_i  = 1'b1;
    wide_data_i  = 64'h0000_0000_0000_B301;
    #1;
    check_eq("hole_last_sel", sel_o, 1'b1);
    check_eq("hole_last_data", data_o, 64'h0000_0000_0000_B301);
    cycle();

    // Backpressure: narrow presented, wide (favoured) arrives; grant held.
    wide_valid_i = 1'b0;
    ready_i      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i >= 1) begin
        wide_valid_i = 1'b1;
        wide_last_i  = 1'b0;
        wide_data_i  = 64'h0000_0000_0000_B500;
      end
      #1;
      check_eq("stall_sel", sel_o, 1'b0);
      check_eq("stall_valid", valid_o, 1'b1);
      check_eq("stall_data", data_o, 64'h0000_0000_0000_A300);
      check_eq("stall_wready", wide_ready_o, 1'b0);
      cycle();
    end
    ready_i = 1'b1;
    #1;
    check_eq("unstall_sel", sel_o, 1'b0);
    check_eq("unstall_nready", narrow_ready_o, 1'b1);
    cycle();

    // Reset in the middle of a wide burst.
    narrow_valid_i = 1'b0;
    #1;
    check_eq("pre_rst_sel", sel_o, 1'b1);
    cycle();
    narrow_valid_i = 1'b1;
    narrow_data_i  = 64'h0000_0000_0000_A600;
    wide_data_i    = 64'h0000_0000_0000_B501;
    #1;
    check_eq("mid_burst_sel", sel_o, 1'b1);
    check_eq("mid_burst_nready", narrow_ready_o, 1'b0);
    rst_ni = 1'b0;
    #1;
    check_eq("async_rst_valid", valid_o, 1'b0);
    check_eq("async_rst_sel", sel_o, 1'b0);
    check_eq("async_rst_wready", wide_ready_o, 1'b0);
    check_eq("async_rst_data", data_o, 64'h0000_0000_0000_A600);
    cycle();
    cycle();
    rst_ni       = 1'b1;
    wide_last_i  = 1'b1;
    wide_data_i  = 64'h0000_0000_0000_B600;
    #1;
    check_eq("post_rst_sel", sel_o, 1'b0);
    check_eq("post_rst_nready", narrow_ready_o, 1'b1);
    check_eq("post_rst_data", data_o, 64'h0000_0000_0000_A600);
    cycle();
    narrow_valid_i = 1'b0;
    #1;
    check_eq("post_rst_wide_sel", sel_o, 1'b1);
    check_eq("post_rst_wide_data", data_o, 64'h0000_0000_0000_B600);
    cycle();
    wide_valid_i = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
